// File: rtl/i3c_pkg.sv
// Shared I3C target definitions: CCC codes, the max-length handler state
// encoding, reset values of the committed lengths and the length clamp helper.
package i3c_pkg;

    localparam logic [7:0] SETMWL_BCAST  = 8'h09;
    localparam logic [7:0] SETMWL_DIRECT = 8'h89;
    localparam logic [7:0] SETMRL_BCAST  = 8'h0A;
    localparam logic [7:0] SETMRL_DIRECT = 8'h8A;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MSB   = 3'd1,
        LSB   = 3'd2,
        IBIL  = 3'd3,
        DRAIN = 3'd4
    } ccc_len_state_e;

    localparam logic [15:0] MWL_RST  = 16'd256;
    localparam logic [15:0] MRL_RST  = 16'd256;
    localparam logic [7:0]  IBIL_RST = 8'd255;

    // Bound a requested length into [lo, hi].
    function automatic logic [15:0] clamp_len(input logic [15:0] raw,
                                              input logic [15:0] lo,
                                              input logic [15:0] hi);
        if (raw < lo) begin
            return lo;
        end else if (raw > hi) begin
            return hi;
        end else begin
            return raw;
        end
    endfunction

endpackage

// File: rtl/ccc_max_len_handler.sv
// Target-side SETMWL/SETMRL handler. Collects the MSB-first length payload
// from the CCC decoder and pulses commit strobes towards the configuration
// block so GETMWL/GETMRL and the IBI length readback stay current.
// Optional feature: define CCC_MAX_LEN_CLAMP_EN to clamp committed MWL/MRL
// into [MIN_LEN, MAX_LEN] and flag out-of-range requests on err_o.
module ccc_max_len_handler
    import i3c_pkg::*;
#(
    parameter logic [15:0] MIN_LEN = 16'd8,
    parameter logic [15:0] MAX_LEN = 16'd256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ccc_valid_i,
    input  logic [7:0]  ccc_code_i,
    input  logic        data_valid_i,
    input  logic [7:0]  data_i,
    input  logic        data_last_i,
    output logic        data_ready_o,
    input  logic        bus_stop_i,
    input  logic        ibi_payload_en_i,
    output logic        set_mwl_o,
    output logic        set_mrl_o,
    output logic        set_ibil_o,
    output logic [15:0] mwl_o,
    output logic [15:0] mrl_o,
    output logic [7:0]  ibil_o,
    output logic        err_o,
    output logic        busy_o
);

`ifdef CCC_MAX_LEN_CLAMP_EN
    localparam bit CLAMP_EN = 1'b1;
`else
    localparam bit CLAMP_EN = 1'b0;
`endif

    ccc_len_state_e r_state, w_state_nxt;
    logic        r_kind_mrl, w_kind_mrl_nxt;
    logic        r_drain_skip, w_drain_skip_nxt;
    logic        r_drain_errd, w_drain_errd_nxt;
    logic [7:0]  r_hi, r_lo;
    logic [15:0] r_mwl, r_mrl;
    logic [7:0]  r_ibil;
    logic        r_set_mwl, r_set_mrl, r_set_ibil, r_err;

    logic        w_hs, w_len_ccc, w_code_mrl;
    logic        w_cm_mwl, w_cm_mrl, w_cm_ibil, w_err, w_hi_ld, w_lo_ld;
    logic [15:0] w_raw, w_len;
    logic        w_rng_err;

    assign w_len_ccc  = (ccc_code_i == SETMWL_BCAST) || (ccc_code_i == SETMWL_DIRECT) ||
                        (ccc_code_i == SETMRL_BCAST) || (ccc_code_i == SETMRL_DIRECT);
    assign w_code_mrl = (ccc_code_i == SETMRL_BCAST) || (ccc_code_i == SETMRL_DIRECT);

    assign data_ready_o = (r_state != IDLE);
    assign busy_o       = (r_state != IDLE);
    assign w_hs         = data_valid_i && data_ready_o;

    // In IBIL the MRL value was completed one byte earlier and is held in hi/lo.
    assign w_raw     = (r_state == IBIL) ? {r_hi, r_lo} : {r_hi, data_i};
    assign w_len     = CLAMP_EN ? clamp_len(w_raw, MIN_LEN, MAX_LEN) : w_raw;
    assign w_rng_err = CLAMP_EN && ((w_raw < MIN_LEN) || (w_raw > MAX_LEN));

    assign set_mwl_o  = r_set_mwl;
    assign set_mrl_o  = r_set_mrl;
    assign set_ibil_o = r_set_ibil;
    assign mwl_o      = r_mwl;
    assign mrl_o      = r_mrl;
    assign ibil_o     = r_ibil;
    assign err_o      = r_err;

    // Control state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_kind_mrl   <= 1'b0;
            r_drain_skip <= 1'b0;
            r_drain_errd <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_kind_mrl   <= w_kind_mrl_nxt;
            r_drain_skip <= w_drain_skip_nxt;
            r_drain_errd <= w_drain_errd_nxt;
        end
    end

    // Next state and commit decisions; a new CCC wins over STOP, STOP wins over data.
    always_comb begin
        w_state_nxt      = r_state;
        w_kind_mrl_nxt   = r_kind_mrl;
        w_drain_skip_nxt = r_drain_skip;
        w_drain_errd_nxt = r_drain_errd;
        w_cm_mwl         = 1'b0;
        w_cm_mrl         = 1'b0;
        w_cm_ibil        = 1'b0;
        w_err            = 1'b0;
        w_hi_ld          = 1'b0;
        w_lo_ld          = 1'b0;
        if (ccc_valid_i && w_len_ccc) begin
            w_state_nxt    = MSB;
            w_kind_mrl_nxt = w_code_mrl;
        end else if (bus_stop_i) begin
            w_state_nxt = IDLE;
        end else if (w_hs) begin
            case (r_state)
                MSB: begin
                    w_hi_ld = 1'b1;
                    if (data_last_i) begin
                        w_err       = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = LSB;
                    end
                end
                LSB: begin
                    if (!r_kind_mrl) begin
                        w_cm_mwl         = 1'b1;
                        w_state_nxt      = data_last_i ? IDLE : DRAIN;
                        w_drain_skip_nxt = 1'b0;
                        w_drain_errd_nxt = 1'b0;
                    end else if (data_last_i || !ibi_payload_en_i) begin
                        w_cm_mrl         = 1'b1;
                        w_state_nxt      = data_last_i ? IDLE : DRAIN;
                        // The optional IBI-length byte is tolerated even when unused.
                        w_drain_skip_nxt = !data_last_i;
                        w_drain_errd_nxt = 1'b0;
                    end else begin
                        w_lo_ld     = 1'b1;
                        w_state_nxt = IBIL;
                    end
                end
                IBIL: begin
                    w_cm_mrl         = 1'b1;
                    w_cm_ibil        = 1'b1;
                    w_state_nxt      = data_last_i ? IDLE : DRAIN;
                    w_drain_skip_nxt = 1'b0;
                    w_drain_errd_nxt = 1'b0;
                end
                DRAIN: begin
                    if (r_drain_skip) begin
                        w_drain_skip_nxt = 1'b0;
                    end else if (!r_drain_errd) begin
                        w_err            = 1'b1;
                        w_drain_errd_nxt = 1'b1;
                    end
                    if (data_last_i) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Committed values and one-cycle strobes, aligned one cycle after the byte.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_set_mwl  <= 1'b0;
            r_set_mrl  <= 1'b0;
            r_set_ibil <= 1'b0;
            r_err      <= 1'b0;
            r_mwl      <= MWL_RST;
            r_mrl      <= MRL_RST;
            r_ibil     <= IBIL_RST;
        end else begin
            r_set_mwl  <= w_cm_mwl;
            r_set_mrl  <= w_cm_mrl;
            r_set_ibil <= w_cm_ibil;
            r_err      <= w_err || ((w_cm_mwl || w_cm_mrl) && w_rng_err);
            if (w_cm_mwl) begin
                r_mwl <= w_len;
            end
            if (w_cm_mrl) begin
                r_mrl <= w_len;
            end
            if (w_cm_ibil) begin
                r_ibil <= data_i;
            end
        end
    end

    // Payload byte holding registers; contents only matter while a payload is open.
    always_ff @(posedge clk_i) begin
        if (w_hi_ld) begin
            r_hi <= data_i;
        end
        if (w_lo_ld) begin
            r_lo <= data_i;
        end
    end

endmodule

// File: tb/tb_ccc_max_len_handler.sv
// Bench for ccc_max_len_handler: directed scenarios followed by randomized
// CCC transactions compared against a transaction-level reference model.
module tb_ccc_max_len_handler;

    logic        clk = 1'b0;
    logic        rst_i, ccc_valid_i, data_valid_i, data_last_i, bus_stop_i, ibi_payload_en_i;
    logic [7:0]  ccc_code_i, data_i;
    logic        data_ready_o, set_mwl_o, set_mrl_o, set_ibil_o, err_o, busy_o;
    logic [15:0] mwl_o, mrl_o;
    logic [7:0]  ibil_o;

    always #5 clk = ~clk;

    ccc_max_len_handler dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .ccc_valid_i      (ccc_valid_i),
        .ccc_code_i       (ccc_code_i),
        .data_valid_i     (data_valid_i),
        .data_i           (data_i),
        .data_last_i      (data_last_i),
        .data_ready_o     (data_ready_o),
        .bus_stop_i       (bus_stop_i),
        .ibi_payload_en_i (ibi_payload_en_i),
        .set_mwl_o        (set_mwl_o),
        .set_mrl_o        (set_mrl_o),
        .set_ibil_o       (set_ibil_o),
        .mwl_o            (mwl_o),
        .mrl_o            (mrl_o),
        .ibil_o           (ibil_o),
        .err_o            (err_o),
        .busy_o           (busy_o)
    );

    int n_vec = 0;
    int n_mis = 0;

    // Activity monitor counters, cleared per transaction.
    int m_mwl = 0, m_mrl = 0, m_ibil = 0, m_pair = 0, m_err = 0, lat_bad = 0, stab_bad = 0;
    logic        mon_hs, mon_rs;
    logic [15:0] prev_mwl, prev_mrl;
    logic [7:0]  prev_ibil;

    // Expected committed state.
    logic [15:0] e_mwl = 16'd256, e_mrl = 16'd256;
    logic [7:0]  e_ibil = 8'd255;

    logic [7:0] tb_bytes [8];
    logic [7:0] codes [4];

    always @(posedge clk) begin
        mon_hs = data_valid_i & data_ready_o;
        mon_rs = rst_i;
        #1;
        if (!mon_rs) begin
            if (set_mwl_o) m_mwl++;
            if (set_mrl_o) m_mrl++;
            if (set_ibil_o) m_ibil++;
            if (set_ibil_o && set_mrl_o) m_pair++;
            if (err_o) m_err++;
            if ((set_mwl_o || set_mrl_o || set_ibil_o) && !mon_hs) lat_bad++;
            if ((mwl_o !== prev_mwl) && !set_mwl_o) stab_bad++;
            if ((mrl_o !== prev_mrl) && !set_mrl_o) stab_bad++;
            if ((ibil_o !== prev_ibil) && !set_ibil_o) stab_bad++;
        end
        prev_mwl  = mwl_o;
        prev_mrl  = mrl_o;
        prev_ibil = ibil_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_mon();
        m_mwl = 0; m_mrl = 0; m_ibil = 0; m_pair = 0; m_err = 0; lat_bad = 0; stab_bad = 0;
    endtask

    function automatic logic [15:0] ref_len(input logic [15:0] raw);
`ifdef CCC_MAX_LEN_CLAMP_EN
        if (raw < 16'd8) return 16'd8;
        if (raw > 16'd256) return 16'd256;
        return raw;
`else
        return raw;
`endif
    endfunction

    function automatic int ref_rng(input logic [15:0] raw);
`ifdef CCC_MAX_LEN_CLAMP_EN
        return ((raw < 16'd8) || (raw > 16'd256)) ? 1 : 0;
`else
        return (raw === 16'hxxxx) ? 1 : 0;
`endif
    endfunction

    // One CCC with n payload bytes; stop_at >= 0 raises bus_stop on that byte.
    task automatic run_txn(input string tag, input logic [7:0] code, input int n,
                           input logic ibi, input int stop_at);
        int d, x_mwl, x_mrl, x_ibil, x_err;
        logic complete, is_mrl;
        logic [15:0] raw;
        clr_mon();
        ibi_payload_en_i = ibi;
        ccc_code_i  = code;
        ccc_valid_i = 1'b1;
        @(negedge clk);
        ccc_valid_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            data_valid_i = 1'b1;
            data_i       = tb_bytes[i];
            data_last_i  = (i == n - 1);
            bus_stop_i   = (i == stop_at);
            @(negedge clk);
            bus_stop_i = 1'b0;
            if (i == stop_at) break;
        end
        data_valid_i = 1'b0;
        data_last_i  = 1'b0;
        repeat (2) @(negedge clk);

        // Transaction-level expectation.
        d        = (stop_at >= 0 && stop_at < n) ? stop_at : n;
        complete = (d == n);
        is_mrl   = (code == 8'h0A) || (code == 8'h8A);
        raw      = {tb_bytes[0], tb_bytes[1]};
        x_mwl = 0; x_mrl = 0; x_ibil = 0; x_err = 0;
        if (complete && d == 1) x_err++;
        if (!is_mrl) begin
            if (d >= 2) begin
                x_mwl = 1; e_mwl = ref_len(raw); x_err += ref_rng(raw);
                if (d >= 3) x_err++;
            end
        end else if (ibi) begin
            if (d >= 3) begin
                x_mrl = 1; x_ibil = 1; e_mrl = ref_len(raw); e_ibil = tb_bytes[2];
                x_err += ref_rng(raw);
                if (d >= 4) x_err++;
            end else if (d == 2 && complete) begin
                x_mrl = 1; e_mrl = ref_len(raw); x_err += ref_rng(raw);
            end
        end else begin
            if (d >= 2) begin
                x_mrl = 1; e_mrl = ref_len(raw); x_err += ref_rng(raw);
                if (d >= 4) x_err++;
            end
        end

        chk({tag, ".n_set_mwl"}, m_mwl, x_mwl);
        chk({tag, ".n_set_mrl"}, m_mrl, x_mrl);
        chk({tag, ".n_set_ibil"}, m_ibil, x_ibil);
        chk({tag, ".mrl_ibil_pair"}, m_pair, x_ibil);
        chk({tag, ".n_err"}, m_err, x_err);
        chk({tag, ".mwl"}, mwl_o, e_mwl);
        chk({tag, ".mrl"}, mrl_o, e_mrl);
        chk({tag, ".ibil"}, ibil_o, e_ibil);
        chk({tag, ".busy_end"}, busy_o, 1'b0);
        chk({tag, ".latency"}, lat_bad, 0);
        chk({tag, ".stable"}, stab_bad, 0);
    endtask

    initial begin
        int n, stop_at;
        logic [7:0] code;
        logic ibi;
        codes[0] = 8'h09; codes[1] = 8'h89; codes[2] = 8'h0A; codes[3] = 8'h8A;
        rst_i = 1'b1; ccc_valid_i = 1'b0; ccc_code_i = 8'h00; data_valid_i = 1'b0;
        data_i = 8'h00; data_last_i = 1'b0; bus_stop_i = 1'b0; ibi_payload_en_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_i = 1'b0;

        // Reset state.
        chk("rst.mwl", mwl_o, 16'd256);
        chk("rst.mrl", mrl_o, 16'd256);
        chk("rst.ibil", ibil_o, 8'd255);
        chk("rst.busy", busy_o, 1'b0);
        chk("rst.ready", data_ready_o, 1'b0);
        chk("rst.strobes", {set_mwl_o, set_mrl_o, set_ibil_o, err_o}, 4'b0000);

        // Directed scenarios.
        tb_bytes[0] = 8'h00; tb_bytes[1] = 8'h40;
        run_txn("t1_setmwl", 8'h09, 2, 1'b0, -1);
        tb_bytes[0] = 8'h01; tb_bytes[1] = 8'h00; tb_bytes[2] = 8'h20;
        run_txn("t2_setmrl_ibi", 8'h8A, 3, 1'b1, -1);
        tb_bytes[0] = 8'h00; tb_bytes[1] = 8'h80; tb_bytes[2] = 8'h11;
        run_txn("t3_setmrl_noibi", 8'h0A, 3, 1'b0, -1);
        tb_bytes[0] = 8'h12;
        run_txn("t4_short", 8'h09, 1, 1'b0, -1);
        tb_bytes[0] = 8'h00; tb_bytes[1] = 8'h33;
        run_txn("t4_stop", 8'h89, 2, 1'b0, 1);
        tb_bytes[0] = 8'h00; tb_bytes[1] = 8'h04;
        run_txn("t5_low", 8'h09, 2, 1'b0, -1);
        tb_bytes[0] = 8'h10; tb_bytes[1] = 8'h00;
        run_txn("t5_high", 8'h09, 2, 1'b0, -1);
        tb_bytes[0] = 8'h00; tb_bytes[1] = 8'h30; tb_bytes[2] = 8'h44; tb_bytes[3] = 8'h55;
        run_txn("surplus_mwl", 8'h89, 4, 1'b0, -1);
        tb_bytes[0] = 8'h00; tb_bytes[1] = 8'h50; tb_bytes[2] = 8'h44; tb_bytes[3] = 8'h55;
        run_txn("surplus_mrl", 8'h0A, 4, 1'b0, -1);

        // Restart by a new CCC mid-payload: old partial MWL is lost.
        clr_mon();
        ccc_code_i = 8'h09; ccc_valid_i = 1'b1; ibi_payload_en_i = 1'b0;
        @(negedge clk);
        ccc_valid_i = 1'b0; data_valid_i = 1'b1; data_i = 8'h55; data_last_i = 1'b0;
        @(negedge clk);
        data_valid_i = 1'b0; ccc_code_i = 8'h8A; ccc_valid_i = 1'b1;
        @(negedge clk);
        ccc_valid_i = 1'b0; data_valid_i = 1'b1; data_i = 8'h00;
        @(negedge clk);
        data_i = 8'h10; data_last_i = 1'b1;
        @(negedge clk);
        data_valid_i = 1'b0; data_last_i = 1'b0;
        repeat (2) @(negedge clk);
        e_mrl = 16'h0010;
        chk("restart.n_set_mwl", m_mwl, 0);
        chk("restart.n_set_mrl", m_mrl, 1);
        chk("restart.n_err", m_err, 0);
        chk("restart.mwl", mwl_o, e_mwl);
        chk("restart.mrl", mrl_o, e_mrl);

        // Reset in the middle of a payload.
        clr_mon();
        ccc_code_i = 8'h09; ccc_valid_i = 1'b1;
        @(negedge clk);
        ccc_valid_i = 1'b0; data_valid_i = 1'b1; data_i = 8'h01; data_last_i = 1'b0;
        @(negedge clk);
        data_i = 8'h02; data_last_i = 1'b1; rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0; data_valid_i = 1'b0; data_last_i = 1'b0;
        e_mwl = 16'd256; e_mrl = 16'd256; e_ibil = 8'd255;
        chk("t6.mwl", mwl_o, e_mwl);
        chk("t6.mrl", mrl_o, e_mrl);
        chk("t6.ibil", ibil_o, e_ibil);
        chk("t6.busy", busy_o, 1'b0);
        chk("t6.strobes", {set_mwl_o, set_mrl_o, set_ibil_o, err_o}, 4'b0000);
        ccc_code_i = 8'h07; ccc_valid_i = 1'b1;
        @(negedge clk);
        ccc_valid_i = 1'b0; data_valid_i = 1'b1; data_i = 8'h09; data_last_i = 1'b1;
        chk("t6.ccc07_busy", busy_o, 1'b0);
        chk("t6.ccc07_ready", data_ready_o, 1'b0);
        @(negedge clk);
        data_valid_i = 1'b0; data_last_i = 1'b0;
        @(negedge clk);
        chk("t6.no_strobe", m_mwl + m_mrl + m_ibil + m_err, 0);

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            code = codes[$urandom_range(0, 3)];
            n    = $urandom_range(1, 5);
            ibi  = 1'($urandom_range(0, 1));
            stop_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n - 1) : -1;
            tb_bytes[0] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 2)) : 8'($urandom_range(0, 255));
            for (int k = 1; k < 8; k++) tb_bytes[k] = 8'($urandom_range(0, 255));
            run_txn($sformatf("rnd%0d", t), code, n, ibi, stop_at);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
